lc3_memory_ctrl: RTL and testbench
==================================

Name: lc3_memory_ctrl

Overview:
Memory/IO responder for the LC-3 datapath, on the far side of the MIO_EN / R.W / R handshake that the microsequencer polls. It performs word reads and writes to an internal RAM and to the memory-mapped device registers KBSR, KBDR, DSR, DDR and MCR. It asserts the one-cycle ready bit R after a fixed wait-state count, and bridges keyboard input and display output through valid/ready handshakes.

Parameters:
ADDR_W, 12, RAM address width; RAM occupies x0000 to 2^ADDR_W-1.
WAIT_CYCLES, 3, access latency in clocks; legal range is 1 to 15.
INIT_FILE, "", hex preload for the RAM via $readmemh; no preload when empty.

Ports:
i_CLK  in  1  system clock, rising edge.
i_RST_N  in  1  asynchronous active-low reset.
i_MIO_EN  in  1  access request from the control store.
i_R_W  in  1  1 = write, 0 = read.
i_MAR  in  16  access address.
i_MDR  in  16  write data.
o_R  out  1  ready; high for exactly one cycle per access.
o_MEM_DATA  out  16  read data; valid while o_R is high, then held until the next read completes.
i_KB_VALID  in  1  keyboard byte available.
i_KB_DATA  in  8  keyboard byte.
o_KB_READY  out  1  controller can accept a keyboard byte.
o_DISP_VALID  out  1  display byte pending.
o_DISP_DATA  out  8  display byte.
i_DISP_READY  in  1  display has consumed the byte.
o_KB_INT  out  1  KBSR[15] AND KBSR[14].
o_MCR_RUN  out  1  MCR[15], the machine-run bit.

Behaviour:
- Reset (asynchronous, any time):
  - FSM goes to IDLE; o_R=0; o_MEM_DATA=0; counter=0.
  - KBSR=0, KBDR=0, DSR=x8000, DDR=0, MCR=x8000.
  - o_DISP_VALID=0.
  - A write in flight is not committed; RAM contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if i_MIO_EN=1 at the edge, latch i_MAR, i_MDR and i_R_W, load counter with WAIT_CYCLES-1, go to WAIT. Inputs sampled later are ignored.
  - WAIT: decrement the counter each edge. When the counter is 0, go to DONE; at that same edge commit the access (write RAM/register, or capture read data into o_MEM_DATA).
  - DONE: o_R=1 (registered). Return to IDLE unconditionally at the next edge.
  - Latency: with i_MIO_EN sampled at edge k, o_R is high from edge k+WAIT_CYCLES to edge k+WAIT_CYCLES+1.
  - Back-to-back: if i_MIO_EN is still high in the IDLE cycle after DONE, it is a new access. The gap between R pulses is at least one IDLE cycle.
- Address decode (on the latched address):
  - Below 2^ADDR_W: RAM.
  - xFE00 KBSR: bit 15 ready (read-only); bit 14 interrupt enable (read/write); other bits read 0.
  - xFE02 KBDR: reads {8'h00, byte}. A read clears KBSR[15]. Writes are ignored.
  - xFE04 DSR: bit 15 display ready (read-only); other bits read 0.
  - xFE06 DDR: write stores the low byte, sets o_DISP_VALID=1 and DSR[15]=0. Reads return DDR.
  - xFFFE MCR: bit 15 read/write; other bits read 0.
  - Any other address reads x0000; writes to it are dropped.
- Keyboard:
  - o_KB_READY = NOT KBSR[15].
  - At an edge where i_KB_VALID AND o_KB_READY: KBDR<=i_KB_DATA and KBSR[15]<=1.
  - A KBDR read and a byte capture cannot coincide, because KBSR[15]=1 during the read.
  - A KBDR read commits the clear of KBSR[15]; a new byte can be captured from the next edge on.
- Display:
  - While o_DISP_VALID=1, o_DISP_DATA=DDR[7:0] and is stable.
  - At an edge where o_DISP_VALID AND i_DISP_READY: o_DISP_VALID<=0 and DSR[15]<=1.
  - A DDR write while DSR[15]=0 is dropped; DDR is unchanged.
  - If a DDR write commit and a handshake completion fall on the same edge, the completion applies first, then the write is accepted (the new byte becomes pending).
- Writes to read-only bits are ignored.
- RAM is synchronous with a single port, accessed only at the commit edge.

Test Plan:
- Reset, write x1234 to x0010 (WAIT_CYCLES=3), then read x0010 -> each access has o_R high for exactly one cycle, 3 edges after MIO_EN is sampled; the read gives o_MEM_DATA=x1234.
- Hold i_MIO_EN high across 3 read accesses -> three R pulses, each separated by one IDLE cycle; i_MAR changes during WAIT have no effect.
- i_KB_VALID with x41 -> o_KB_READY drops; a read of KBSR gives x8000; a read of KBDR gives x0041; o_KB_READY is 1 again after that commit.
- Write KBSR=x4000 with a byte pending -> o_KB_INT=1; reading KBDR drops o_KB_INT to 0.
- Write DDR=x0048 with i_DISP_READY held low -> o_DISP_VALID=1 and o_DISP_DATA=x48; a read of DSR gives x0000; a second DDR write x0049 is dropped; raising i_DISP_READY gives DSR=x8000.
- Assert i_RST_N=0 midway through WAIT of a write to x0020 -> o_R stays 0 and the old RAM value is retained; write MCR=x0000 -> o_MCR_RUN=0.

Source files
------------

// File: rtl/lc3_memory_ctrl.sv
// LC-3 memory/IO responder: wait-stated RAM plus KBSR/KBDR/DSR/DDR/MCR.
// Answers MIO_EN with a one-cycle R pulse after WAIT_CYCLES clocks.
module lc3_memory_ctrl #(
  parameter int    ADDR_W      = 12,
  parameter int    WAIT_CYCLES = 3,
  parameter string INIT_FILE   = ""
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_MIO_EN,
  input  logic        i_R_W,
  input  logic [15:0] i_MAR,
  input  logic [15:0] i_MDR,
  output logic        o_R,
  output logic [15:0] o_MEM_DATA,
  input  logic        i_KB_VALID,
  input  logic [7:0]  i_KB_DATA,
  output logic        o_KB_READY,
  output logic        o_DISP_VALID,
  output logic [7:0]  o_DISP_DATA,
  input  logic        i_DISP_READY,
  output logic        o_KB_INT,
  output logic        o_MCR_RUN
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] lat_addr, lat_data;
  logic        lat_rw;
  logic        latch, commit;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    commit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_MIO_EN) begin
          latch     = 1'b1;
          cnt_nxt   = 4'(WAIT_CYCLES - 1);
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_rw   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch) begin
        lat_addr <= i_MAR;
        lat_data <= i_MDR;
        lat_rw   <= i_R_W;
      end
    end
  end

  logic sel_ram, sel_kbsr, sel_kbdr;
  logic sel_dsr, sel_ddr, sel_mcr;
  logic wr, rd;

  assign sel_ram  = (lat_addr[15:ADDR_W] == '0);
  assign sel_kbsr = (lat_addr == 16'hFE00);
  assign sel_kbdr = (lat_addr == 16'hFE02);
  assign sel_dsr  = (lat_addr == 16'hFE04);
  assign sel_ddr  = (lat_addr == 16'hFE06);
  assign sel_mcr  = (lat_addr == 16'hFFFE);
  assign wr       = commit & lat_rw;
  assign rd       = commit & ~lat_rw;

  logic        kbsr_rdy, kbsr_ie, dsr_rdy;
  logic        mcr_run, disp_valid;
  logic [7:0]  kbdr, ddr;
  logic [15:0] io_rdata, io_q, ram_q;
  logic        src_ram, disp_done;

  always_comb begin
    io_rdata = '0;
    unique case (1'b1)
      sel_kbsr: io_rdata = {kbsr_rdy, kbsr_ie, 14'h0};
      sel_kbdr: io_rdata = {8'h00, kbdr};
      sel_dsr:  io_rdata = {dsr_rdy, 15'h0};
      sel_ddr:  io_rdata = {8'h00, ddr};
      sel_mcr:  io_rdata = {mcr_run, 15'h0};
      default:  io_rdata = '0;
    endcase
  end

  logic [15:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge i_CLK) begin
    if (commit && sel_ram) begin
      if (lat_rw) mem[lat_addr[ADDR_W-1:0]] <= lat_data;
      else        ram_q <= mem[lat_addr[ADDR_W-1:0]];
    end
  end

  assign disp_done = disp_valid & i_DISP_READY;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      src_ram    <= 1'b0;
      io_q       <= '0;
      kbsr_rdy   <= 1'b0;
      kbsr_ie    <= 1'b0;
      kbdr       <= '0;
      dsr_rdy    <= 1'b1;
      ddr        <= '0;
      mcr_run    <= 1'b1;
      disp_valid <= 1'b0;
    end else begin
      if (rd) begin
        src_ram <= sel_ram;
        io_q    <= io_rdata;
      end
      if (wr && sel_kbsr) kbsr_ie <= lat_data[14];
      if (wr && sel_mcr)  mcr_run <= lat_data[15];
      if (rd && sel_kbdr) kbsr_rdy <= 1'b0;
      if (i_KB_VALID && !kbsr_rdy) begin
        kbdr     <= i_KB_DATA;
        kbsr_rdy <= 1'b1;
      end
      if (disp_done) begin
        disp_valid <= 1'b0;
        dsr_rdy    <= 1'b1;
      end
      if (wr && sel_ddr && (dsr_rdy || disp_done)) begin
        ddr        <= lat_data[7:0];
        disp_valid <= 1'b1;
        dsr_rdy    <= 1'b0;
      end
    end
  end

  assign o_R          = (state == S_DONE);
  assign o_MEM_DATA   = src_ram ? ram_q : io_q;
  assign o_KB_READY   = ~kbsr_rdy;
  assign o_KB_INT     = kbsr_rdy & kbsr_ie;
  assign o_DISP_VALID = disp_valid;
  assign o_DISP_DATA  = ddr;
  assign o_MCR_RUN    = mcr_run;

endmodule

// File: tb/tb_lc3_memory_ctrl.sv
// Directed testbench for lc3_memory_ctrl.
// Each task drives one scenario and checks its own results.
module tb_lc3_memory_ctrl;

  logic        i_CLK = 1'b0;
  logic        i_RST_N = 1'b0;
  logic        i_MIO_EN = 1'b0;
  logic        i_R_W = 1'b0;
  logic [15:0] i_MAR = '0;
  logic [15:0] i_MDR = '0;
  logic        o_R;
  logic [15:0] o_MEM_DATA;
  logic        i_KB_VALID = 1'b0;
  logic [7:0]  i_KB_DATA = '0;
  logic        o_KB_READY;
  logic        o_DISP_VALID;
  logic [7:0]  o_DISP_DATA;
  logic        i_DISP_READY = 1'b0;
  logic        o_KB_INT;
  logic        o_MCR_RUN;

  int tests = 0;
  int fails = 0;

  always #5 i_CLK = ~i_CLK;

  lc3_memory_ctrl dut (
    .i_CLK        (i_CLK),
    .i_RST_N      (i_RST_N),
    .i_MIO_EN     (i_MIO_EN),
    .i_R_W        (i_R_W),
    .i_MAR        (i_MAR),
    .i_MDR        (i_MDR),
    .o_R          (o_R),
    .o_MEM_DATA   (o_MEM_DATA),
    .i_KB_VALID   (i_KB_VALID),
    .i_KB_DATA    (i_KB_DATA),
    .o_KB_READY   (o_KB_READY),
    .o_DISP_VALID (o_DISP_VALID),
    .o_DISP_DATA  (o_DISP_DATA),
    .i_DISP_READY (i_DISP_READY),
    .o_KB_INT     (o_KB_INT),
    .o_MCR_RUN    (o_MCR_RUN)
  );

  // One access; lat = edges from MIO_EN sample to R high,
  // r_after = o_R one edge after the pulse.
  task automatic access(input logic rw, input logic [15:0] a,
                        input logic [15:0] d, output int lat,
                        output logic r_after);
    @(negedge i_CLK);
    i_MIO_EN = 1'b1;
    i_R_W    = rw;
    i_MAR    = a;
    i_MDR    = d;
    @(posedge i_CLK);
    #1 i_MIO_EN = 1'b0;
    i_MAR = 16'hFFFF;
    i_MDR = 16'hFFFF;
    lat = 0;
    while (o_R !== 1'b1 && lat < 20) begin
      @(posedge i_CLK);
      #1 lat++;
    end
    @(posedge i_CLK);
    #1 r_after = o_R;
  endtask

  task automatic test_reset;
    i_RST_N = 1'b0;
    repeat (2) @(posedge i_CLK);
    #1;
    tests++;
    if (o_R !== 1'b0) begin
      fails++;
      $display("FAIL reset_r got %b want 0", o_R);
    end
    tests++;
    if (o_MEM_DATA !== 16'h0000) begin
      fails++;
      $display("FAIL reset_data got %h want 0000", o_MEM_DATA);
    end
    tests++;
    if ({o_KB_READY, o_DISP_VALID, o_KB_INT, o_MCR_RUN} !== 4'b1001) begin
      fails++;
      $display("FAIL reset_flags got %b want 1001",
               {o_KB_READY, o_DISP_VALID, o_KB_INT, o_MCR_RUN});
    end
    @(negedge i_CLK);
    i_RST_N = 1'b1;
  endtask

  task automatic test_read_write;
    int   lat;
    logic ra;
    access(1'b1, 16'h0010, 16'h1234, lat, ra);
    tests++;
    if (lat !== 3 || ra !== 1'b0) begin
      fails++;
      $display("FAIL wr_latency got %0d/%b want 3/0", lat, ra);
    end
    access(1'b0, 16'h0010, 16'h0000, lat, ra);
    tests++;
    if (lat !== 3 || ra !== 1'b0) begin
      fails++;
      $display("FAIL rd_latency got %0d/%b want 3/0", lat, ra);
    end
    tests++;
    if (o_MEM_DATA !== 16'h1234) begin
      fails++;
      $display("FAIL rd_data got %h want 1234", o_MEM_DATA);
    end
    access(1'b1, 16'h0FFF, 16'hDEAD, lat, ra);
    access(1'b1, 16'hF000, 16'hBEEF, lat, ra);
    access(1'b0, 16'hF000, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'h0000) begin
      fails++;
      $display("FAIL unmapped got %h want 0000", o_MEM_DATA);
    end
  endtask

  // MIO_EN held high; MAR only valid in the IDLE sample cycles.
  task automatic test_back_to_back;
    int pulses = 0;
    logic want;
    @(negedge i_CLK);
    i_MIO_EN = 1'b1;
    i_R_W    = 1'b0;
    i_MAR    = 16'h0010;
    @(posedge i_CLK);
    #1 i_MAR = 16'h0FFF;
    for (int e = 1; e <= 13; e++) begin
      @(posedge i_CLK);
      #1;
      want = (e == 3 || e == 8 || e == 13);
      tests++;
      if (o_R !== want) begin
        fails++;
        $display("FAIL b2b_r edge %0d got %b want %b", e, o_R, want);
      end
      if (o_R === 1'b1) begin
        pulses++;
        tests++;
        if (o_MEM_DATA !== 16'h1234) begin
          fails++;
          $display("FAIL b2b_data got %h want 1234", o_MEM_DATA);
        end
      end
      i_MAR = (e == 4 || e == 9) ? 16'h0010 : 16'h0FFF;
      if (e == 13) i_MIO_EN = 1'b0;
    end
    @(posedge i_CLK);
    #1;
    tests++;
    if (pulses !== 3 || o_R !== 1'b0) begin
      fails++;
      $display("FAIL b2b_count got %0d want 3", pulses);
    end
  endtask

  task automatic kb_send(input logic [7:0] b);
    @(negedge i_CLK);
    i_KB_VALID = 1'b1;
    i_KB_DATA  = b;
    @(posedge i_CLK);
    #1 i_KB_VALID = 1'b0;
  endtask

  task automatic test_keyboard;
    int   lat;
    logic ra;
    kb_send(8'h41);
    tests++;
    if (o_KB_READY !== 1'b0) begin
      fails++;
      $display("FAIL kb_ready_low got %b want 0", o_KB_READY);
    end
    access(1'b0, 16'hFE00, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'h8000) begin
      fails++;
      $display("FAIL kbsr got %h want 8000", o_MEM_DATA);
    end
    access(1'b0, 16'hFE02, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'h0041) begin
      fails++;
      $display("FAIL kbdr got %h want 0041", o_MEM_DATA);
    end
    tests++;
    if (o_KB_READY !== 1'b1) begin
      fails++;
      $display("FAIL kb_ready_back got %b want 1", o_KB_READY);
    end
  endtask

  task automatic test_kb_int;
    int   lat;
    logic ra;
    kb_send(8'h5A);
    access(1'b1, 16'hFE00, 16'h4000, lat, ra);
    tests++;
    if (o_KB_INT !== 1'b1) begin
      fails++;
      $display("FAIL kb_int_on got %b want 1", o_KB_INT);
    end
    access(1'b0, 16'hFE00, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'hC000) begin
      fails++;
      $display("FAIL kbsr_ie got %h want c000", o_MEM_DATA);
    end
    access(1'b0, 16'hFE02, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'h005A || o_KB_INT !== 1'b0) begin
      fails++;
      $display("FAIL kb_int_off got %h/%b want 005a/0",
               o_MEM_DATA, o_KB_INT);
    end
  endtask

  task automatic test_display;
    int   lat;
    logic ra;
    i_DISP_READY = 1'b0;
    access(1'b1, 16'hFE06, 16'h0048, lat, ra);
    tests++;
    if (o_DISP_VALID !== 1'b1 || o_DISP_DATA !== 8'h48) begin
      fails++;
      $display("FAIL disp_pend got %b/%h want 1/48",
               o_DISP_VALID, o_DISP_DATA);
    end
    access(1'b0, 16'hFE04, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'h0000) begin
      fails++;
      $display("FAIL dsr_busy got %h want 0000", o_MEM_DATA);
    end
    access(1'b1, 16'hFE06, 16'h0049, lat, ra);
    access(1'b0, 16'hFE06, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'h0048 || o_DISP_DATA !== 8'h48) begin
      fails++;
      $display("FAIL ddr_drop got %h/%h want 0048/48",
               o_MEM_DATA, o_DISP_DATA);
    end
    @(negedge i_CLK);
    i_DISP_READY = 1'b1;
    @(posedge i_CLK);
    #1 i_DISP_READY = 1'b0;
    tests++;
    if (o_DISP_VALID !== 1'b0) begin
      fails++;
      $display("FAIL disp_done got %b want 0", o_DISP_VALID);
    end
    access(1'b0, 16'hFE04, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'h8000) begin
      fails++;
      $display("FAIL dsr_ready got %h want 8000", o_MEM_DATA);
    end
  endtask

  task automatic test_reset_mid_write;
    int   lat;
    int   rhi = 0;
    logic ra;
    access(1'b1, 16'h0020, 16'hABCD, lat, ra);
    @(negedge i_CLK);
    i_MIO_EN = 1'b1;
    i_R_W    = 1'b1;
    i_MAR    = 16'h0020;
    i_MDR    = 16'h1111;
    @(posedge i_CLK);
    #1 i_MIO_EN = 1'b0;
    @(posedge i_CLK);
    #2 i_RST_N = 1'b0;
    for (int e = 0; e < 6; e++) begin
      if (e == 2) i_RST_N = 1'b1;
      @(posedge i_CLK);
      #1 if (o_R !== 1'b0) rhi++;
    end
    tests++;
    if (rhi !== 0) begin
      fails++;
      $display("FAIL rst_r got %0d pulses want 0", rhi);
    end
    access(1'b0, 16'h0020, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'hABCD) begin
      fails++;
      $display("FAIL rst_keep got %h want abcd", o_MEM_DATA);
    end
    tests++;
    if (o_MCR_RUN !== 1'b1) begin
      fails++;
      $display("FAIL mcr_reset got %b want 1", o_MCR_RUN);
    end
    access(1'b1, 16'hFFFE, 16'h0000, lat, ra);
    tests++;
    if (o_MCR_RUN !== 1'b0) begin
      fails++;
      $display("FAIL mcr_clear got %b want 0", o_MCR_RUN);
    end
    access(1'b0, 16'hFFFE, 16'h0000, lat, ra);
    tests++;
    if (o_MEM_DATA !== 16'h0000) begin
      fails++;
      $display("FAIL mcr_read got %h want 0000", o_MEM_DATA);
    end
  endtask

  initial begin
    test_reset();
    test_read_write();
    test_back_to_back();
    test_keyboard();
    test_kb_int();
    test_display();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
